// File: rtl/video_pkg.sv
// Shared raster defaults, pixel type and clear-state encoding for the VGA frame buffer path.
package video_pkg;

  localparam int unsigned H_TOTAL_DEF  = 800;
  localparam int unsigned V_TOTAL_DEF  = 525;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned CH_W_DEF     = 4;

  typedef struct packed {
    logic [CH_W_DEF-1:0] r;
    logic [CH_W_DEF-1:0] g;
    logic [CH_W_DEF-1:0] b;
  } rgb_t;

  typedef enum logic {
    StIdle,
    StClear
  } clr_state_e;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port pixel RAM: one write port, registered read-first read port with enable.
module fb_ram
  import video_pkg::*;
#(
  parameter int unsigned Depth = 19200,
  parameter int unsigned Width = 12,
  localparam int unsigned Aw   = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [Aw-1:0]    waddr,
  input  logic [Width-1:0] wdata,
  input  logic             re,
  input  logic [Aw-1:0]    raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // No reset: contents survive rst; a same-address read sees the pre-write value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/video_frame_buffer.sv
// Frame buffer with 2^SCALE_SHIFT replicated raster scanout and random-access pixel writes.
// Optional buffer clear FSM is built when FB_CLEAR_EN is defined.
module video_frame_buffer
  import video_pkg::*;
#(
  parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned CH_W        = CH_W_DEF,
  localparam int unsigned FB_W       = H_ACTIVE >> SCALE_SHIFT,
  localparam int unsigned FB_H       = V_ACTIVE >> SCALE_SHIFT,
  localparam int unsigned DEPTH      = FB_W * FB_H,
  localparam int unsigned XW         = $clog2(FB_W),
  localparam int unsigned YW         = $clog2(FB_H),
  localparam int unsigned HW         = $clog2(H_TOTAL),
  localparam int unsigned VW         = $clog2(V_TOTAL),
  localparam int unsigned AW         = $clog2(DEPTH),
  localparam int unsigned PW         = 3 * CH_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            px_en,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [XW-1:0]   wr_x,
  input  logic [YW-1:0]   wr_y,
  input  logic [PW-1:0]   wr_rgb,
  input  logic            clear_req,
  output logic            busy,
  output logic [HW-1:0]   hcount,
  output logic [VW-1:0]   vcount,
  output logic            frame_start,
  output logic            pix_active,
  output logic [CH_W-1:0] vr,
  output logic [CH_W-1:0] vg,
  output logic [CH_W-1:0] vb
);

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          vis1_q, vis1_d;
  logic          active_q, active_d;
  logic [PW-1:0] rgb_q, rgb_d;

  logic          h_wrap, v_wrap, visible;
  logic [AW-1:0] fetch_addr, wr_addr;
  logic          wr_in_range;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [PW-1:0] ram_wdata, ram_rdata;

  // Raster counters and scanout pipeline.
  always_comb begin
    h_wrap   = (hcount_q == HW'(H_TOTAL - 1));
    v_wrap   = (vcount_q == VW'(V_TOTAL - 1));
    visible  = (hcount_q < HW'(H_ACTIVE)) && (vcount_q < VW'(V_ACTIVE));
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    vis1_d   = vis1_q;
    active_d = active_q;
    rgb_d    = rgb_q;
    if (px_en) begin
      if (h_wrap) begin
        hcount_d = '0;
        vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
      vis1_d   = visible;
      active_d = vis1_q;
      // Stale RAM data is never shown during blanking.
      rgb_d    = vis1_q ? ram_rdata : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      vis1_q   <= 1'b0;
      active_q <= 1'b0;
      rgb_q    <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      vis1_q   <= vis1_d;
      active_q <= active_d;
      rgb_q    <= rgb_d;
    end
  end

  always_comb begin
    fetch_addr  = AW'(vcount_q >> SCALE_SHIFT) * AW'(FB_W) + AW'(hcount_q >> SCALE_SHIFT);
    wr_addr     = AW'(wr_y) * AW'(FB_W) + AW'(wr_x);
    wr_in_range = ({1'b0, wr_x} < (XW + 1)'(FB_W)) && ({1'b0, wr_y} < (YW + 1)'(FB_H));
  end

`ifdef FB_CLEAR_EN
  clr_state_e    state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          clearing;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d    = StClear;
          clr_addr_d = '0;
        end
      end
      StClear: begin
        if (clr_addr_q == AW'(DEPTH - 1)) begin
          state_d = StIdle;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign clearing = (state_q == StClear);
  assign busy     = clearing;
  assign wr_ready = ~clearing;

  // A clear_req sampled in IDLE swallows any write offered in the same cycle.
  always_comb begin
    ram_we    = clearing | (wr_valid & ~clear_req & wr_in_range);
    ram_waddr = clearing ? clr_addr_q : wr_addr;
    ram_wdata = clearing ? '0 : wr_rgb;
  end
`else
  logic unused_clear_req;

  assign unused_clear_req = clear_req;
  assign busy             = 1'b0;
  assign wr_ready         = 1'b1;

  always_comb begin
    ram_we    = wr_valid & wr_in_range;
    ram_waddr = wr_addr;
    ram_wdata = wr_rgb;
  end
`endif

  fb_ram #(
    .Depth(DEPTH),
    .Width(PW)
  ) u_fb_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (px_en & visible),
    .raddr(fetch_addr),
    .rdata(ram_rdata)
  );

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign frame_start = px_en & h_wrap & v_wrap;
  assign pix_active  = active_q;
  assign vr          = rgb_q[PW-1:2*CH_W];
  assign vg          = rgb_q[2*CH_W-1:CH_W];
  assign vb          = rgb_q[CH_W-1:0];

endmodule

// File: tb/tb_video_frame_buffer.sv
// Randomised bench for video_frame_buffer on a reduced raster, checked against a
// frame-level model (pixel array plus a two-tick display delay line).
module tb_video_frame_buffer;

  localparam int unsigned HT    = 50;
  localparam int unsigned VT    = 30;
  localparam int unsigned HA    = 40;
  localparam int unsigned VA    = 24;
  localparam int unsigned SS    = 2;
  localparam int unsigned CH    = 4;
  localparam int unsigned FBW   = HA >> SS;
  localparam int unsigned FBH   = VA >> SS;
  localparam int unsigned DEPTH = FBW * FBH;
  localparam int unsigned XW    = $clog2(FBW);
  localparam int unsigned YW    = $clog2(FBH);
  localparam int unsigned HW    = $clog2(HT);
  localparam int unsigned VW    = $clog2(VT);
  localparam int unsigned FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          rst, px_en, wr_valid, clear_req;
  logic          wr_ready, busy, frame_start, pix_active;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [11:0]   wr_rgb;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic [CH-1:0] vr, vg, vb;

  always #5 clk = ~clk;

  video_frame_buffer #(
    .H_TOTAL    (HT),
    .V_TOTAL    (VT),
    .H_ACTIVE   (HA),
    .V_ACTIVE   (VA),
    .SCALE_SHIFT(SS),
    .CH_W       (CH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .px_en      (px_en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_rgb     (wr_rgb),
    .clear_req  (clear_req),
    .busy       (busy),
    .hcount     (hcount),
    .vcount     (vcount),
    .frame_start(frame_start),
    .pix_active (pix_active),
    .vr         (vr),
    .vg         (vg),
    .vb         (vb)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Model state: stored image, px_en tick count, pixels queued for display, clear progress.
  logic [11:0] ref_mem [DEPTH];
  int unsigned ticks;
  logic [12:0] hist [$];
  bit          m_busy;
  int unsigned m_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ticks  = 0;
    hist   = '{13'h0, 13'h0};
    m_busy = 1'b0;
  endtask

  // One clock: drive inputs, check outputs at negedge, advance the model at posedge.
  task automatic cycle(input bit en, input bit wv, input int unsigned x, input int unsigned y,
                       input logic [11:0] rgb, input bit clr);
    int unsigned h, v;
    logic [12:0] f;
    px_en     = en;
    wr_valid  = wv;
    wr_x      = XW'(x);
    wr_y      = YW'(y);
    wr_rgb    = rgb;
    clear_req = clr;
    @(negedge clk);
    h = ticks % HT;
    v = (ticks / HT) % VT;
    check("hcount", hcount, h);
    check("vcount", vcount, v);
    check("frame_start", frame_start, en && h == HT - 1 && v == VT - 1);
    check("pix_active", pix_active, hist[0][12]);
    check("rgb", {vr, vg, vb}, hist[0][11:0]);
    check("busy", busy, m_busy);
    check("wr_ready", wr_ready, !m_busy);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (en) begin
        f = 13'h0;
        if (h < HA && v < VA) f = {1'b1, ref_mem[(v >> SS) * FBW + (h >> SS)]};
        hist.push_back(f);
        void'(hist.pop_front());
        ticks++;
      end
`ifdef FB_CLEAR_EN
      if (m_busy) begin
        ref_mem[m_idx] = 12'h0;
        m_idx++;
        if (m_idx == DEPTH) m_busy = 1'b0;
      end else if (clr) begin
        m_busy = 1'b1;
        m_idx  = 0;
      end else if (wv && x < FBW && y < FBH) begin
        ref_mem[y * FBW + x] = rgb;
      end
`else
      if (wv && x < FBW && y < FBH) ref_mem[y * FBW + x] = rgb;
`endif
    end
    #1;
  endtask

  task automatic idle_cycle(input bit en);
    cycle(en, 1'b0, 0, 0, 12'h0, 1'b0);
  endtask

  task automatic rand_cycle(input int unsigned wr_pct);
    cycle($urandom_range(0, 3) != 0, $urandom_range(0, 99) < wr_pct,
          $urandom_range(0, (1 << XW) - 1), $urandom_range(0, (1 << YW) - 1),
          12'($urandom_range(0, 4095)), 1'b0);
  endtask

  task automatic scan_ticks(input int unsigned nticks, input int unsigned wr_pct);
    int unsigned target, guard;
    target = ticks + nticks;
    guard  = 0;
    while (ticks < target && guard < nticks * 8) begin
      rand_cycle(wr_pct);
      guard++;
    end
    check("scan_bound", ticks >= target, 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < int'(DEPTH); i++) begin
      cycle(1'b0, 1'b1, i % FBW, i / FBW, 12'($urandom_range(0, 4095)), 1'b0);
    end
  endtask

  // Asynchronous assert between edges, checked immediately, then held n clocks.
  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    check("rst_active", pix_active, 0);
    check("rst_rgb", {vr, vg, vb}, 0);
    repeat (n) idle_cycle($urandom_range(0, 1) != 0);
    rst = 1'b0;
  endtask

  initial begin
    int unsigned busy_cnt, guard;
    rst       = 1'b1;
    px_en     = 1'b0;
    wr_valid  = 1'b0;
    clear_req = 1'b0;
    wr_x      = '0;
    wr_y      = '0;
    wr_rgb    = '0;
    model_reset();
    repeat (2) idle_cycle(1'b0);
    rst = 1'b0;

    fill_random();
    cycle(1'b0, 1'b1, 3, 2, 12'hF80, 1'b0);
    cycle(1'b0, 1'b1, FBW + 2, 0, 12'hFFF, 1'b0);
    cycle(1'b0, 1'b1, 3, FBH + 1, 12'hFFF, 1'b0);
    cycle(1'b0, 1'b1, (1 << XW) - 1, (1 << YW) - 1, 12'hFFF, 1'b0);
    scan_ticks(2 * FRAME + 2, 0);

    // Writes racing the scanout: read-first and one-clock write latency.
    scan_ticks(FRAME + 2, 30);

    scan_ticks(FRAME / 3, 10);
    do_reset(3);
    scan_ticks(FRAME + 2, 0);

    // Full clear, with a write offered alongside clear_req.
    cycle(1'b1, 1'b1, 4, 4, 12'hABC, 1'b1);
    busy_cnt = 0;
    for (int g = 0; g < int'(DEPTH) + 6; g++) begin
      if (busy) busy_cnt++;
      rand_cycle(0);
    end
`ifdef FB_CLEAR_EN
    check("clear_len", busy_cnt, DEPTH);
`else
    check("clear_len", busy_cnt, 0);
`endif
    scan_ticks(FRAME + 2, 0);

    // Reset halfway through a clear; the dropped write targets the preserved half.
    fill_random();
    cycle(1'b0, 1'b1, FBW - 1, FBH - 1, 12'h5A5, 1'b1);
    guard = 0;
    while (m_busy && m_idx != DEPTH / 2 && guard < DEPTH + 4) begin
      rand_cycle(0);
      guard++;
    end
    do_reset(2);
    scan_ticks(FRAME + 2, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
